// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-pass shift sequencer driving an external 2-bit barrel shifter
// Optional out_zero result flag enabled by macro SHIFT_SEQUENCER_ZERO_FLAG_EN.
module shift_sequencer #(
    parameter int STEP_MAX = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [1:0] in_mode,
    input  logic [3:0] in_amt,
    output logic [7:0] sh_data_in,
    output logic [1:0] sh_mode,
    output logic [1:0] sh_size,
    input  logic [7:0] sh_data_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
`ifdef SHIFT_SEQUENCER_ZERO_FLAG_EN
    output logic       out_zero,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] STEP = 4'(STEP_MAX);

    state_t     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [1:0] mode_q, mode_d;
    logic [3:0] rem_q, rem_d;
    logic [7:0] sh_data_in_q, sh_data_in_d;
    logic [1:0] sh_mode_q, sh_mode_d;
    logic [1:0] sh_size_q, sh_size_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       busy_q, busy_d;
    logic       in_ready_q, in_ready_d;
    logic       zero_q, zero_d;
    logic [3:0] rem_nxt;

    function automatic logic [1:0] step_of(input logic [3:0] r);
        if (r > STEP) return STEP[1:0];
        return r[1:0];
    endfunction

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        mode_d       = mode_q;
        rem_d        = rem_q;
        sh_data_in_d = sh_data_in_q;
        sh_mode_d    = sh_mode_q;
        sh_size_d    = sh_size_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        busy_d       = busy_q;
        in_ready_d   = in_ready_q;
        zero_d       = zero_q;
        rem_nxt      = rem_q - {2'b00, sh_size_q};
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d      = in_data;
                    mode_d     = in_mode;
                    rem_d      = in_amt;
                    busy_d     = 1'b1;
                    in_ready_d = 1'b0;
                    if (in_amt != 4'd0) begin
                        state_d      = RUN;
                        sh_data_in_d = in_data;
                        sh_mode_d    = in_mode;
                        sh_size_d    = step_of(in_amt);
                    end else begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        out_data_d  = in_data;
                        zero_d      = (in_data == 8'h00);
                    end
                end
            end
            RUN: begin
                acc_d = sh_data_out;
                rem_d = rem_nxt;
                if (rem_nxt == 4'd0) begin
                    state_d     = DONE;
                    sh_size_d   = 2'd0;
                    out_valid_d = 1'b1;
                    out_data_d  = sh_data_out;
                    zero_d      = (sh_data_out == 8'h00);
                end else begin
                    // Next pass is presented from registers, never from sh_data_out directly
                    sh_data_in_d = sh_data_out;
                    sh_size_d    = step_of(rem_nxt);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                    zero_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= 8'h00;
            mode_q       <= 2'd0;
            rem_q        <= 4'd0;
            sh_data_in_q <= 8'h00;
            sh_mode_q    <= 2'd0;
            sh_size_q    <= 2'd0;
            out_data_q   <= 8'h00;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b1;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            mode_q       <= mode_d;
            rem_q        <= rem_d;
            sh_data_in_q <= sh_data_in_d;
            sh_mode_q    <= sh_mode_d;
            sh_size_q    <= sh_size_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            in_ready_q   <= in_ready_d;
            zero_q       <= zero_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign sh_data_in = sh_data_in_q;
    assign sh_mode    = sh_mode_q;
    assign sh_size    = sh_size_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign busy       = busy_q;
`ifdef SHIFT_SEQUENCER_ZERO_FLAG_EN
    assign out_zero   = zero_q;
`else
    logic unused_zero;
    assign unused_zero = zero_q;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench for shift_sequencer with a behavioural barrel shifter
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_mode;
    logic [3:0] in_amt;
    logic [7:0] sh_data_in;
    logic [1:0] sh_mode;
    logic [1:0] sh_size;
    logic [7:0] sh_data_out;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
`ifdef SHIFT_SEQUENCER_ZERO_FLAG_EN
    logic       out_zero;
`endif

    shift_sequencer #(.STEP_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .in_amt(in_amt),
        .sh_data_in(sh_data_in), .sh_mode(sh_mode), .sh_size(sh_size),
        .sh_data_out(sh_data_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef SHIFT_SEQUENCER_ZERO_FLAG_EN
        .out_zero(out_zero),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    logic [15:0] dbl_l, dbl_r;
    always_comb begin
        dbl_l = {sh_data_in, sh_data_in} << sh_size;
        dbl_r = {sh_data_in, sh_data_in} >> sh_size;
        case (sh_mode)
            2'b00:   sh_data_out = sh_data_in << sh_size;
            2'b01:   sh_data_out = sh_data_in >> sh_size;
            2'b10:   sh_data_out = dbl_l[15:8];
            default: sh_data_out = dbl_r[7:0];
        endcase
    end

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  mode;
        int          runs;
        logic [31:0] seq;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts RUN passes, latency and pass sizes per command, checks on result handshake
    int          mn, lat;
    logic [31:0] mseq;
    logic        active, have_prev;
    logic [7:0]  prev;
    exp_t        e;
    initial begin
        active = 0; have_prev = 0; mn = 0; lat = 0; mseq = 0; prev = 0;
    end
    always @(negedge clk) begin
        if (rst) begin
            active = 0; mn = 0; mseq = 0; lat = 0; have_prev = 0;
        end else if (in_valid && in_ready) begin
            active = 1; lat = 0; mn = 0; mseq = 0; have_prev = 0;
        end else if (active) begin
            if (sh_size != 2'd0) begin
                mn++;
                mseq = (mseq << 2) | {30'd0, sh_size};
                if (sb.size() > 0) chk("sh_mode", {30'd0, sh_mode}, {30'd0, sb[0].mode});
            end
            if (!out_valid) begin
                lat++;
            end else begin
                chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
                chk("sh_size_in_done", {30'd0, sh_size}, 32'd0);
                if (have_prev) chk("out_data_stable", {24'd0, out_data}, {24'd0, prev});
                prev = out_data;
                have_prev = 1;
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", {24'd0, out_data}, {24'd0, e.data});
                        chk("run_cycles", mn, e.runs);
                        chk("latency", lat, e.runs);
                        chk("size_seq", mseq, e.seq);
`ifdef SHIFT_SEQUENCER_ZERO_FLAG_EN
                        chk("out_zero", {31'd0, out_zero}, {31'd0, e.zero});
`endif
                    end
                    active = 0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [1:0] m, input logic [3:0] a,
                        input logic [7:0] exp_d, input bit hold);
        exp_t x;
        int   t = 0;
        int   r;
        logic [1:0] s;
        @(posedge clk); #1;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        x.data = exp_d; x.mode = m; x.runs = 0; x.seq = 0; x.zero = (exp_d == 8'h00);
        r = a;
        while (r > 0) begin
            s = (r > 3) ? 2'd3 : 2'(r);
            x.seq = (x.seq << 2) | {30'd0, s};
            x.runs++;
            r -= s;
        end
        sb.push_back(x);
        in_valid = 1; in_data = d; in_mode = m; in_amt = a;
        out_ready = !hold;
        @(posedge clk); #1;
        in_valid = 0;
        in_data = 8'($urandom); in_mode = 2'($urandom); in_amt = 4'($urandom);
        if (hold) begin
            repeat (5) begin @(posedge clk); #1; end
            out_ready = 1;
        end
    endtask

    initial begin
        int t;
        rst = 1; in_valid = 0; in_data = 8'hA5; in_mode = 2'd3; in_amt = 4'd7; out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sh_size", {30'd0, sh_size}, 32'd0);
        chk("rst_sh_mode", {30'd0, sh_mode}, 32'd0);
        chk("rst_sh_data_in", {24'd0, sh_data_in}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        rst = 0;
        // Unhandshaked inputs must not start anything
        in_valid = 0; in_data = 8'h3C; in_amt = 4'd5;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);

        send(8'h6B, 2'b00, 4'd2,  8'hAC, 0);
        send(8'h6B, 2'b11, 4'd5,  8'h5B, 0);
        send(8'h6B, 2'b10, 4'd8,  8'h6B, 0);
        send(8'hFF, 2'b01, 4'd15, 8'h00, 0);
        send(8'h5A, 2'b00, 4'd0,  8'h5A, 1);
        send(8'h81, 2'b10, 4'd1,  8'h03, 0);
        send(8'h81, 2'b01, 4'd7,  8'h01, 0);
        send(8'h96, 2'b11, 4'd4,  8'h69, 0);
        send(8'h6B, 2'b00, 4'd8,  8'h00, 0);

        // Abort mid-command: reset in the second RUN cycle
        send(8'hFF, 2'b01, 4'd15, 8'h00, 0);
        @(posedge clk); #1;
        rst = 1;
        sb.delete();
        #1;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_sh_size", {30'd0, sh_size}, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        repeat (6) begin
            @(posedge clk); #1;
            chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
        end
        send(8'h6B, 2'b11, 4'd5, 8'h5B, 0);

        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
